// File: rtl/game_pkg.sv
// Shared encodings for the match controller: phases, player state codes,
// round winner codes and hit/hurt box coordinate width.
package game_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [2:0] {
        PH_IDLE       = 3'd0,
        PH_COUNTDOWN  = 3'd1,
        PH_FIGHT      = 3'd2,
        PH_ROUND_END  = 3'd3,
        PH_MATCH_OVER = 3'd4
    } phase_t;

    localparam logic [3:0] ST_ATTACK_END = 4'd4;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_DRAW = 2'd3
    } winner_t;

    function automatic logic [COORD_W-1:0] cmin(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    function automatic logic [COORD_W-1:0] cmax(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        return (a < b) ? b : a;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Normalises two axis-aligned boxes (corners may arrive swapped) and
// reports whether they overlap, edges inclusive.
module box_overlap
    import game_pkg::*;
(
    input  logic [COORD_W-1:0] a_x1,
    input  logic [COORD_W-1:0] a_x2,
    input  logic [COORD_W-1:0] a_y1,
    input  logic [COORD_W-1:0] a_y2,
    input  logic [COORD_W-1:0] b_x1,
    input  logic [COORD_W-1:0] b_x2,
    input  logic [COORD_W-1:0] b_y1,
    input  logic [COORD_W-1:0] b_y2,
    output logic               overlap
);

    logic [COORD_W-1:0] axl, axh, ayl, ayh;
    logic [COORD_W-1:0] bxl, bxh, byl, byh;

    always_comb begin
        axl = cmin(a_x1, a_x2);
        axh = cmax(a_x1, a_x2);
        ayl = cmin(a_y1, a_y2);
        ayh = cmax(a_y1, a_y2);
        bxl = cmin(b_x1, b_x2);
        bxh = cmax(b_x1, b_x2);
        byl = cmin(b_y1, b_y2);
        byh = cmax(b_y1, b_y2);
    end

    assign overlap = (axl <= bxh) && (bxl <= axh) &&
                     (ayl <= byh) && (byl <= ayh);

endmodule

// File: rtl/match_controller.sv
// Two-player match sequencer: phases, hit resolution, health, wins, input gating.
// Define HITSTUN_EN to add per-player input lockout after taking a hit.
module match_controller
    import game_pkg::*;
#(
    parameter int MAX_HP           = 10,
    parameter int DAMAGE           = 1,
    parameter int COUNTDOWN_FRAMES = 60,
    parameter int ROUNDEND_FRAMES  = 120,
    parameter int HITSTUN_FRAMES   = 12,
    parameter int WINS_TO_MATCH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               p1_left_i,
    input  logic               p1_right_i,
    input  logic               p1_attack_i,
    input  logic               p2_left_i,
    input  logic               p2_right_i,
    input  logic               p2_attack_i,
    output logic               p1_left_o,
    output logic               p1_right_o,
    output logic               p1_attack_o,
    output logic               p2_left_o,
    output logic               p2_right_o,
    output logic               p2_attack_o,
    input  logic [3:0]         p1_state,
    input  logic [3:0]         p2_state,
    input  logic [COORD_W-1:0] p1_hit_x1,
    input  logic [COORD_W-1:0] p1_hit_x2,
    input  logic [COORD_W-1:0] p1_hit_y1,
    input  logic [COORD_W-1:0] p1_hit_y2,
    input  logic [COORD_W-1:0] p2_hit_x1,
    input  logic [COORD_W-1:0] p2_hit_x2,
    input  logic [COORD_W-1:0] p2_hit_y1,
    input  logic [COORD_W-1:0] p2_hit_y2,
    input  logic [COORD_W-1:0] p1_hurt_x1,
    input  logic [COORD_W-1:0] p1_hurt_x2,
    input  logic [COORD_W-1:0] p1_hurt_y1,
    input  logic [COORD_W-1:0] p1_hurt_y2,
    input  logic [COORD_W-1:0] p2_hurt_x1,
    input  logic [COORD_W-1:0] p2_hurt_x2,
    input  logic [COORD_W-1:0] p2_hurt_y1,
    input  logic [COORD_W-1:0] p2_hurt_y2,
    output logic               players_rst,
    output logic [2:0]         phase,
    output logic [3:0]         p1_health,
    output logic [3:0]         p2_health,
    output logic [1:0]         p1_wins,
    output logic [1:0]         p2_wins,
    output logic [1:0]         winner,
    output logic               p1_stunned,
    output logic               p2_stunned
);

    localparam logic [3:0] HP_LOAD   = 4'(MAX_HP);
    localparam logic [3:0] DMG       = 4'(DAMAGE);
    localparam logic [7:0] CD_LOAD   = 8'(COUNTDOWN_FRAMES - 1);
    localparam logic [7:0] RE_LOAD   = 8'(ROUNDEND_FRAMES - 1);
    localparam logic [3:0] STUN_LOAD = 4'(HITSTUN_FRAMES);
    localparam logic [1:0] W2M       = 2'(WINS_TO_MATCH);

    phase_t     ph, ph_n;
    winner_t    win_q;
    logic [7:0] cnt;
    logic [3:0] hp1, hp2, hp1_hit, hp2_hit;
    logic [1:0] w1, w2;
    logic       hd1, hd2;
    logic       ov12, ov21, hit1, hit2;
    logic       ko1, ko2, wins_done;
    logic       enter_cd, enter_re, fight;

    function automatic logic [3:0] take_hit(input logic [3:0] h, input logic hit);
        if (!hit) return h;
        return (h <= DMG) ? 4'd0 : h - DMG;
    endfunction

    function automatic logic [1:0] win_inc(input logic [1:0] w);
        return (w == 2'd3) ? w : w + 2'd1;
    endfunction

    box_overlap u_ov12 (
        .a_x1(p1_hit_x1), .a_x2(p1_hit_x2),
        .a_y1(p1_hit_y1), .a_y2(p1_hit_y2),
        .b_x1(p2_hurt_x1), .b_x2(p2_hurt_x2),
        .b_y1(p2_hurt_y1), .b_y2(p2_hurt_y2),
        .overlap(ov12)
    );

    box_overlap u_ov21 (
        .a_x1(p2_hit_x1), .a_x2(p2_hit_x2),
        .a_y1(p2_hit_y1), .a_y2(p2_hit_y2),
        .b_x1(p1_hurt_x1), .b_x2(p1_hurt_x2),
        .b_y1(p1_hurt_y1), .b_y2(p1_hurt_y2),
        .overlap(ov21)
    );

    assign fight = (ph == PH_FIGHT);
    // hit1: P1 lands on P2; hd* limits each attack to one hit
    assign hit1 = fight && (p1_state == ST_ATTACK_END) && ov12 && !hd1;
    assign hit2 = fight && (p2_state == ST_ATTACK_END) && ov21 && !hd2;

    assign hp1_hit   = take_hit(hp1, hit2);
    assign hp2_hit   = take_hit(hp2, hit1);
    assign ko1       = (hp1_hit == 4'd0);
    assign ko2       = (hp2_hit == 4'd0);
    assign wins_done = (w1 == W2M) || (w2 == W2M);

    always_comb begin
        ph_n = ph;
        unique case (ph)
            PH_IDLE:       if (start) ph_n = PH_COUNTDOWN;
            PH_COUNTDOWN:  if (cnt == 8'd0) ph_n = PH_FIGHT;
            PH_FIGHT:      if (ko1 || ko2) ph_n = PH_ROUND_END;
            PH_ROUND_END:
                if (cnt == 8'd0)
                    ph_n = wins_done ? PH_MATCH_OVER : PH_COUNTDOWN;
            PH_MATCH_OVER: if (start) ph_n = PH_COUNTDOWN;
            default:       ph_n = PH_IDLE;
        endcase
    end

    assign enter_cd = (ph_n == PH_COUNTDOWN) && (ph != PH_COUNTDOWN);
    assign enter_re = (ph_n == PH_ROUND_END) && (ph != PH_ROUND_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph          <= PH_IDLE;
            cnt         <= 8'd0;
            players_rst <= 1'b1;
            hp1         <= HP_LOAD;
            hp2         <= HP_LOAD;
            w1          <= 2'd0;
            w2          <= 2'd0;
            win_q       <= WIN_NONE;
            hd1         <= 1'b0;
            hd2         <= 1'b0;
        end else begin
            ph          <= ph_n;
            players_rst <= (ph_n == PH_IDLE) || (ph_n == PH_COUNTDOWN) ||
                           (ph_n == PH_MATCH_OVER);
            hd1         <= (p1_state == ST_ATTACK_END) && (hd1 || hit1);
            hd2         <= (p2_state == ST_ATTACK_END) && (hd2 || hit2);

            if (enter_cd)
                cnt <= CD_LOAD;
            else if (enter_re)
                cnt <= RE_LOAD;
            else if (cnt != 8'd0)
                cnt <= cnt - 8'd1;

            if (enter_cd) begin
                hp1 <= HP_LOAD;
                hp2 <= HP_LOAD;
            end else if (fight) begin
                hp1 <= hp1_hit;
                hp2 <= hp2_hit;
            end

            if (enter_cd && (ph == PH_MATCH_OVER)) begin
                w1    <= 2'd0;
                w2    <= 2'd0;
                win_q <= WIN_NONE;
            end else if (fight && (ko1 || ko2)) begin
                if (ko1 && ko2) begin
                    win_q <= WIN_DRAW;
                end else if (ko1) begin
                    win_q <= WIN_P2;
                    w2    <= win_inc(w2);
                end else begin
                    win_q <= WIN_P1;
                    w1    <= win_inc(w1);
                end
            end
        end
    end

`ifdef HITSTUN_EN
    logic [3:0] stun1, stun2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stun1 <= 4'd0;
            stun2 <= 4'd0;
        end else if (enter_cd) begin
            stun1 <= 4'd0;
            stun2 <= 4'd0;
        end else begin
            if (hit2)
                stun1 <= STUN_LOAD;
            else if (stun1 != 4'd0)
                stun1 <= stun1 - 4'd1;
            if (hit1)
                stun2 <= STUN_LOAD;
            else if (stun2 != 4'd0)
                stun2 <= stun2 - 4'd1;
        end
    end

    assign p1_stunned = (stun1 != 4'd0);
    assign p2_stunned = (stun2 != 4'd0);
`else
    logic unused_stun_cfg;
    assign unused_stun_cfg = ^STUN_LOAD;
    assign p1_stunned = 1'b0;
    assign p2_stunned = 1'b0;
`endif

    assign p1_left_o   = p1_left_i   & fight & ~p1_stunned;
    assign p1_right_o  = p1_right_i  & fight & ~p1_stunned;
    assign p1_attack_o = p1_attack_i & fight & ~p1_stunned;
    assign p2_left_o   = p2_left_i   & fight & ~p2_stunned;
    assign p2_right_o  = p2_right_i  & fight & ~p2_stunned;
    assign p2_attack_o = p2_attack_i & fight & ~p2_stunned;

    assign phase     = ph;
    assign p1_health = hp1;
    assign p2_health = hp2;
    assign p1_wins   = w1;
    assign p2_wins   = w2;
    assign winner    = win_q;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: reference model pushes expected
// outputs each frame, a monitor pops and compares them on the falling edge.
module tb_match_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] b1 = 3'd0, b2 = 3'd0;
    logic [3:0] s1 = 4'd0, s2 = 4'd0;
    logic [9:0] hb1[4], hu1[4], hb2[4], hu2[4];

    logic       p1l, p1r, p1a, p2l, p2r, p2a;
    logic       players_rst, p1_stunned, p2_stunned;
    logic [2:0] phase;
    logic [3:0] p1_health, p2_health;
    logic [1:0] p1_wins, p2_wins, winner;

    always #5 clk = ~clk;

    match_controller dut (
        .clk(clk), .rst(rst), .start(start),
        .p1_left_i(b1[2]), .p1_right_i(b1[1]), .p1_attack_i(b1[0]),
        .p2_left_i(b2[2]), .p2_right_i(b2[1]), .p2_attack_i(b2[0]),
        .p1_left_o(p1l), .p1_right_o(p1r), .p1_attack_o(p1a),
        .p2_left_o(p2l), .p2_right_o(p2r), .p2_attack_o(p2a),
        .p1_state(s1), .p2_state(s2),
        .p1_hit_x1(hb1[0]), .p1_hit_x2(hb1[1]),
        .p1_hit_y1(hb1[2]), .p1_hit_y2(hb1[3]),
        .p2_hit_x1(hb2[0]), .p2_hit_x2(hb2[1]),
        .p2_hit_y1(hb2[2]), .p2_hit_y2(hb2[3]),
        .p1_hurt_x1(hu1[0]), .p1_hurt_x2(hu1[1]),
        .p1_hurt_y1(hu1[2]), .p1_hurt_y2(hu1[3]),
        .p2_hurt_x1(hu2[0]), .p2_hurt_x2(hu2[1]),
        .p2_hurt_y1(hu2[2]), .p2_hurt_y2(hu2[3]),
        .players_rst(players_rst), .phase(phase),
        .p1_health(p1_health), .p2_health(p2_health),
        .p1_wins(p1_wins), .p2_wins(p2_wins), .winner(winner),
        .p1_stunned(p1_stunned), .p2_stunned(p2_stunned)
    );

    typedef struct {
        int ph, prst, h1, h2, w1, w2, win, st1, st2, g;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // next-cycle stimulus, applied just after an edge
    logic       n_rst = 1'b1, n_start = 1'b0;
    logic [3:0] n_s1 = 4'd0, n_s2 = 4'd0;
    logic [9:0] n_hb1[4], n_hu1[4], n_hb2[4], n_hu2[4];

    // inputs the DUT saw during the current cycle
    logic       sn_rst, sn_start;
    logic [3:0] sn_s1, sn_s2;
    logic [9:0] sn_hb1[4], sn_hu1[4], sn_hb2[4], sn_hu2[4];

    int m_ph, m_rem, m_h1, m_h2, m_w1, m_w2, m_win, m_st1, m_st2;
    bit m_d1, m_d2;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a < b) ? b : a;
    endfunction

    function automatic bit ov(input logic [9:0] a[4], input logic [9:0] b[4]);
        bit r = 1'b1;
        for (int ax = 0; ax < 2; ax++) begin
            int lo, hi;
            lo = imax(imin(a[2*ax], a[2*ax+1]), imin(b[2*ax], b[2*ax+1]));
            hi = imin(imax(a[2*ax], a[2*ax+1]), imax(b[2*ax], b[2*ax+1]));
            if (lo > hi) r = 1'b0;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_rem = 0; m_h1 = 10; m_h2 = 10;
        m_w1 = 0; m_w2 = 0; m_win = 0; m_st1 = 0; m_st2 = 0;
        m_d1 = 0; m_d2 = 0;
    endtask

    task automatic enter_countdown();
        m_ph = 1; m_rem = 60; m_h1 = 10; m_h2 = 10; m_st1 = 0; m_st2 = 0;
    endtask

    task automatic model_edge();
        bit on2, on1;
        on2 = (m_ph == 2) && (sn_s1 == 4) && !m_d1 && ov(sn_hb1, sn_hu2);
        on1 = (m_ph == 2) && (sn_s2 == 4) && !m_d2 && ov(sn_hb2, sn_hu1);
        m_d1 = (sn_s1 == 4) && (m_d1 || on2);
        m_d2 = (sn_s2 == 4) && (m_d2 || on1);
`ifdef HITSTUN_EN
        if (on1) m_st1 = 12; else if (m_st1 > 0) m_st1--;
        if (on2) m_st2 = 12; else if (m_st2 > 0) m_st2--;
`endif
        case (m_ph)
            0: if (sn_start) enter_countdown();
            1: begin
                m_rem--;
                if (m_rem == 0) m_ph = 2;
            end
            2: begin
                m_h1 = imax(0, m_h1 - (on1 ? 1 : 0));
                m_h2 = imax(0, m_h2 - (on2 ? 1 : 0));
                if (m_h1 == 0 || m_h2 == 0) begin
                    if (m_h1 == 0 && m_h2 == 0) m_win = 3;
                    else if (m_h1 == 0) begin m_win = 2; m_w2 = imin(m_w2 + 1, 3); end
                    else begin m_win = 1; m_w1 = imin(m_w1 + 1, 3); end
                    m_ph = 3;
                    m_rem = 120;
                end
            end
            3: begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_w1 == 2 || m_w2 == 2) m_ph = 4;
                    else enter_countdown();
                end
            end
            default: if (sn_start) begin
                m_w1 = 0; m_w2 = 0; m_win = 0;
                enter_countdown();
            end
        endcase
    endtask

    task automatic snap();
        sn_rst = rst; sn_start = start; sn_s1 = s1; sn_s2 = s2;
        sn_hb1 = hb1; sn_hu1 = hu1; sn_hb2 = hb2; sn_hu2 = hu2;
    endtask

    task automatic commit();
        exp_t e;
        bit   en1, en2;
        if (rst) model_reset();
        snap();
        en1 = (m_ph == 2) && (m_st1 == 0);
        en2 = (m_ph == 2) && (m_st2 == 0);
        e.ph   = m_ph;
        e.prst = (m_ph == 0 || m_ph == 1 || m_ph == 4) ? 1 : 0;
        e.h1 = m_h1; e.h2 = m_h2; e.w1 = m_w1; e.w2 = m_w2; e.win = m_win;
        e.st1 = (m_st1 > 0) ? 1 : 0;
        e.st2 = (m_st2 > 0) ? 1 : 0;
        e.g = (en1 ? int'(b1) << 3 : 0) | (en2 ? int'(b2) : 0);
        q.push_back(e);
    endtask

    task automatic hold(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (sn_rst) model_reset();
            else model_edge();
            rst = n_rst; start = n_start; s1 = n_s1; s2 = n_s2;
            hb1 = n_hb1; hu1 = n_hu1; hb2 = n_hb2; hu2 = n_hu2;
            b1 = 3'($urandom); b2 = 3'($urandom);
            commit();
        end
    endtask

    task automatic chk(string nm, int act, int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("phase", phase, e.ph);
                chk("players_rst", players_rst, e.prst);
                chk("p1_health", p1_health, e.h1);
                chk("p2_health", p2_health, e.h2);
                chk("p1_wins", p1_wins, e.w1);
                chk("p2_wins", p2_wins, e.w2);
                chk("winner", winner, e.win);
                chk("p1_stunned", p1_stunned, e.st1);
                chk("p2_stunned", p2_stunned, e.st2);
                chk("gated", {p1l, p1r, p1a, p2l, p2r, p2a}, e.g);
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            hb1[i] = 10'd0; hu1[i] = 10'd0; hb2[i] = 10'd0; hu2[i] = 10'd0;
            n_hb1[i] = 10'd0; n_hu1[i] = 10'd0; n_hb2[i] = 10'd0; n_hu2[i] = 10'd0;
        end
        model_reset();
        snap();

        hold(3);
        n_rst = 1'b0;
        hold(3);
        n_start = 1'b1; hold(1); n_start = 1'b0;
        hold(62);

        n_hb1 = '{10'd450, 10'd520, 10'd100, 10'd200};
        n_hu2 = '{10'd501, 10'd448, 10'd50, 10'd150};
        n_hb2 = '{10'd290, 10'd220, 10'd100, 10'd200};
        n_hu1 = '{10'd200, 10'd300, 10'd100, 10'd200};
        n_s1 = 4'd4; hold(3); n_s1 = 4'd0; hold(1);
        n_s1 = 4'd4; hold(3); n_s1 = 4'd0; hold(1);

        n_hb1 = '{10'd245, 10'd323, 10'd100, 10'd200};
        n_hu2 = '{10'd501, 10'd324, 10'd100, 10'd200};
        n_s1 = 4'd4; hold(2); n_s1 = 4'd0; hold(1);
        n_hb1[1] = 10'd324;
        n_s1 = 4'd4; hold(2); n_s1 = 4'd0; hold(1);

        for (int i = 0; i < 20 && m_h2 > 1; i++) begin
            n_s1 = 4'd4; hold(1); n_s1 = 4'd0; hold(1);
        end
        for (int i = 0; i < 20 && m_h1 > 1; i++) begin
            n_s2 = 4'd4; hold(1); n_s2 = 4'd0; hold(1);
        end
        n_s1 = 4'd4; n_s2 = 4'd4; hold(1);
        n_s1 = 4'd0; n_s2 = 4'd0; hold(2);
        for (int i = 0; i < 300 && m_ph != 2; i++) hold(1);

        n_s2 = 4'd0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 30 && m_ph != 3; i++) begin
                n_s1 = 4'd4; hold(1); n_s1 = 4'd0; hold(1);
            end
            for (int i = 0; i < 300 && m_ph != 2 && m_ph != 4; i++) hold(1);
        end
        hold(3);
        n_start = 1'b1; hold(1); n_start = 1'b0;
        hold(62);

        n_s1 = 4'd4; hold(2); n_s1 = 4'd0; hold(3);
        n_rst = 1'b1; hold(2); n_rst = 1'b0; hold(3);

        for (int i = 0; i < 2500; i++) begin
            n_rst = ($urandom_range(0, 799) == 0);
            n_start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                n_s1 = $urandom_range(0, 1) ? 4'd4 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                n_s2 = $urandom_range(0, 1) ? 4'd4 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < 4; k++) begin
                    n_hb1[k] = 10'(200 + $urandom_range(0, 250));
                    n_hu1[k] = 10'(200 + $urandom_range(0, 250));
                    n_hb2[k] = 10'(200 + $urandom_range(0, 250));
                    n_hu2[k] = 10'(200 + $urandom_range(0, 250));
                end
            end
            hold(1);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
